uart_stream_bridge: RTL and testbench
=====================================

// Module: uart_stream_bridge
// PURPOSE
//  Bridges valid/ready byte streams to the UART core's strobe interface (CSN/WEN/OEN, TXRDY/RXRDY).
//  Sits between fabric logic and the UART core.
//  TX path: 1-entry hold register, written to the UART when TXRDY=1.
//  RX path: drains the UART on RXRDY into a small FIFO, tagging each byte with its parity/framing status.
//  Also keeps saturating error counters and a sticky overflow flag.
// PARAMETERS
//  RX_DEPTH    4  RX FIFO entries; power of 2, >=2
//  TX_HOLDOFF  2  cycles after a write strobe during which UART_TXRDY is ignored (range 1..15)
//  RD_HOLDOFF  2  cycles after a read strobe during which UART_RXRDY is ignored (range 1..15)
//  DROP_ERR    1  1 = discard bytes with parity/framing error; 0 = push them with rx_err=1
// PORTS
//  CLK               in   1  system clock, same clock as the UART core
//  RESET_N           in   1  asynchronous active-low reset
//  tx_data           in   8  byte to transmit
//  tx_valid          in   1  tx_data valid
//  tx_ready          out  1  hold register empty; byte accepted when tx_valid&tx_ready
//  rx_data           out  8  received byte (FIFO head)
//  rx_err            out  1  head byte had a parity or framing error (always 0 when DROP_ERR=1)
//  rx_valid          out  1  FIFO not empty
//  rx_ready          in   1  consumer pops head when rx_valid&rx_ready
//  UART_CSN          out  1  chip select to UART, active low
//  UART_WEN          out  1  write strobe to UART, active low
//  UART_OEN          out  1  read strobe to UART, active low
//  UART_DATA_IN      out  8  write data to UART
//  UART_DATA_OUT     in   8  read data from UART
//  UART_TXRDY        in   1  UART can accept a byte
//  UART_RXRDY        in   1  UART holds a received byte
//  UART_PARITY_ERR   in   1  parity error on the current UART byte
//  UART_FRAMING_ERR  in   1  framing error on the current UART byte
//  UART_OVERFLOW     in   1  UART receiver overflow
//  clr_status        in   1  1-cycle pulse: clear counters and sticky flag
//  parity_err_cnt    out  8  parity errors, saturating at 255
//  framing_err_cnt   out  8  framing errors, saturating at 255
//  overflow_sticky   out  1  set when UART_OVERFLOW=1, held until clr_status
// BEHAVIOUR
//  Reset (async, RESET_N=0), all registered:
//   UART_CSN/WEN/OEN=1, UART_DATA_IN=0, tx_ready=1, rx_valid=0, rx_data=0, rx_err=0.
//   Counters=0, overflow_sticky=0, FSM=IDLE, FIFO empty, hold register empty, holdoff counters=0.
//   A strobe in flight is truncated immediately.
//  Strobe outputs are decoded from the registered state only; they never glitch.
//  CSN/WEN/OEN are never low together with WEN and OEN both low.
//  TX accept: tx_valid&tx_ready loads hold register; tx_ready=0 from the next cycle until the write strobe cycle.
//  FSM states: IDLE, WR, WR_WAIT, RD, RD_WAIT.
//   IDLE->WR when hold full & UART_TXRDY & tx holdoff=0 & (grant=write).
//   IDLE->RD when UART_RXRDY & FIFO not full & rx holdoff=0 & (grant=read).
//   Both eligible: round-robin, the one not granted last. After reset, read is granted first.
//   WR: exactly 1 cycle CSN=0, WEN=0, UART_DATA_IN=hold. Hold register empties at end of cycle (tx_ready=1 next cycle).
//     Load tx holdoff=TX_HOLDOFF. ->WR_WAIT.
//   RD: exactly 1 cycle CSN=0, OEN=0. At the closing edge, sample UART_DATA_OUT, PARITY_ERR and FRAMING_ERR.
//     Load rx holdoff=RD_HOLDOFF. ->RD_WAIT.
//   WR_WAIT/RD_WAIT: 1 cycle -> IDLE.
//   Holdoff counters decrement every cycle to 0 independently of state. Min write-to-write spacing = 2+TX_HOLDOFF cycles.
//  RX push at end of RD: err = PARITY_ERR|FRAMING_ERR.
//   If err & DROP_ERR=1, no push, but counters still update. Otherwise push {err,data}.
//  FIFO: simultaneous push and pop are legal at any fill level; the pointer wraps mod RX_DEPTH.
//   RD is never entered when full, so the FIFO never overflows.
//   Pop when empty is ignored. rx_data/rx_err show the head with 0-cycle latency.
//  Counters: +1 per sampled error event, saturating at 255 (no wrap).
//   clr_status together with an event gives a result of 1 (clear first, then count).
//  overflow_sticky: clr_status together with UART_OVERFLOW=1 leaves it at 1.
// TESTING
//  Reset, push 0xA5 with TXRDY=1 -> UART_DATA_IN=0xA5 with CSN=WEN=0 for exactly 1 cycle, 2 cycles after accept; tx_ready=1 next cycle.
//  Drive TXRDY=1 continuously, offer 3 bytes back-to-back -> write strobes spaced 4 cycles apart (TX_HOLDOFF=2); data in order.
//  RXRDY=1, DATA_OUT=0x3C, then RXRDY low -> one OEN pulse; rx_valid=1, rx_data=0x3C, rx_err=0; no second read within RD_HOLDOFF.
//  DROP_ERR=1, read with PARITY_ERR=1 -> no FIFO push, parity_err_cnt=1; repeat 300 times -> count stays at 255.
//  rx_ready=0, RXRDY held 1 -> exactly 4 reads, then CSN stays high until one pop, then 1 more read.
//  TX and RX pending together -> reads and writes alternate; assert RESET_N=0 during RD -> OEN=1 at once, FIFO empty.

Source files
------------

// File: rtl/uart_stream_bridge.sv
// Valid/ready byte-stream front end for a strobe-driven UART core: single-entry TX hold
// register, status-tagged RX FIFO, saturating error counters and a sticky overflow flag.
module uart_stream_bridge #(
   parameter int unsigned RX_DEPTH   = 4,
   parameter int unsigned TX_HOLDOFF = 2,
   parameter int unsigned RD_HOLDOFF = 2,
   parameter bit          DROP_ERR   = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_err,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       UART_CSN,
   output logic       UART_WEN,
   output logic       UART_OEN,
   output logic [7:0] UART_DATA_IN,
   input  logic [7:0] UART_DATA_OUT,
   input  logic       UART_TXRDY,
   input  logic       UART_RXRDY,
   input  logic       UART_PARITY_ERR,
   input  logic       UART_FRAMING_ERR,
   input  logic       UART_OVERFLOW,
   input  logic       clr_status,
   output logic [7:0] parity_err_cnt,
   output logic [7:0] framing_err_cnt,
   output logic       overflow_sticky
);
   localparam int unsigned PW       = $clog2(RX_DEPTH);
   localparam logic [PW:0] FULL_LVL = RX_DEPTH[PW:0];
   localparam logic [3:0]  TX_LOAD  = TX_HOLDOFF[3:0];
   localparam logic [3:0]  RD_LOAD  = RD_HOLDOFF[3:0];

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR      = 3'd1;
   localparam logic [2:0] WR_WAIT = 3'd2;
   localparam logic [2:0] RD      = 3'd3;
   localparam logic [2:0] RD_WAIT = 3'd4;

   logic [2:0]    state, state_nx;
   logic [7:0]    hold_data;
   logic          hold_empty;
   logic [3:0]    tx_wait, rd_wait;
   logic          last_wr;
   logic [8:0]    fifo_mem [RX_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   fill;
   logic          wr_elig, rd_elig, fifo_full, rd_done, smp_err;
   logic          push, pop, par_evt, frm_evt;

   assign tx_ready = hold_empty;
   assign rx_valid = (fill != '0);
   assign rx_data  = fifo_mem[rd_ptr][7:0];
   assign rx_err   = fifo_mem[rd_ptr][8];

   always_comb begin
      fifo_full = (fill == FULL_LVL);
      wr_elig   = !hold_empty && UART_TXRDY && (tx_wait == '0);
      rd_elig   = UART_RXRDY && !fifo_full && (rd_wait == '0);
      rd_done   = (state == RD);
      smp_err   = UART_PARITY_ERR | UART_FRAMING_ERR;
      par_evt   = rd_done && UART_PARITY_ERR;
      frm_evt   = rd_done && UART_FRAMING_ERR;
      push      = rd_done && !(smp_err && DROP_ERR);
      pop       = rx_ready && rx_valid;
      state_nx  = state;
      case (state)
         IDLE: begin
            // When both sides are eligible, serve the one not granted last.
            if (wr_elig && rd_elig) state_nx = last_wr ? RD : WR;
            else if (wr_elig)       state_nx = WR;
            else if (rd_elig)       state_nx = RD;
         end
         WR:      state_nx = WR_WAIT;
         RD:      state_nx = RD_WAIT;
         WR_WAIT: state_nx = IDLE;
         RD_WAIT: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Strobes are registered from the next state so they change only on clock edges.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         UART_CSN     <= 1'b1;
         UART_WEN     <= 1'b1;
         UART_OEN     <= 1'b1;
         UART_DATA_IN <= '0;
         last_wr      <= 1'b1;
      end else begin
         state    <= state_nx;
         UART_CSN <= !((state_nx == WR) || (state_nx == RD));
         UART_WEN <= !(state_nx == WR);
         UART_OEN <= !(state_nx == RD);
         if (state_nx == WR) begin
            UART_DATA_IN <= hold_data;
            last_wr      <= 1'b1;
         end else if (state_nx == RD) begin
            last_wr      <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hold_data  <= '0;
         hold_empty <= 1'b1;
      end else if (state == WR) begin
         hold_empty <= 1'b1;
      end else if (tx_valid && hold_empty) begin
         hold_data  <= tx_data;
         hold_empty <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         tx_wait <= '0;
         rd_wait <= '0;
      end else begin
         if (state == WR)        tx_wait <= TX_LOAD;
         else if (tx_wait != '0) tx_wait <= tx_wait - 4'd1;
         if (state == RD)        rd_wait <= RD_LOAD;
         else if (rd_wait != '0) rd_wait <= rd_wait - 4'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int unsigned i = 0; i < RX_DEPTH; i++) fifo_mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {smp_err, UART_DATA_OUT};
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: ;
         endcase
      end
   end

   // Clear takes effect before the same-cycle event is counted.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         parity_err_cnt  <= '0;
         framing_err_cnt <= '0;
         overflow_sticky <= 1'b0;
      end else begin
         if (clr_status)                             parity_err_cnt <= {7'd0, par_evt};
         else if (par_evt && parity_err_cnt != '1)   parity_err_cnt <= parity_err_cnt + 8'd1;
         if (clr_status)                             framing_err_cnt <= {7'd0, frm_evt};
         else if (frm_evt && framing_err_cnt != '1)  framing_err_cnt <= framing_err_cnt + 8'd1;
         overflow_sticky <= (overflow_sticky && !clr_status) || UART_OVERFLOW;
      end
   end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Scoreboard bench for uart_stream_bridge: directed stimulus pushes expected UART writes and
// RX bytes into queues; a monitor process pops and compares as the DUT presents them.
module tb_uart_stream_bridge;
   localparam logic [7:0] W_EV = 8'h57;
   localparam logic [7:0] R_EV = 8'h52;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_err;
   logic       rx_valid;
   logic       rx_ready;
   logic       UART_CSN, UART_WEN, UART_OEN;
   logic [7:0] UART_DATA_IN;
   logic [7:0] UART_DATA_OUT;
   logic       UART_TXRDY, UART_RXRDY, UART_PARITY_ERR, UART_FRAMING_ERR, UART_OVERFLOW;
   logic       clr_status;
   logic [7:0] parity_err_cnt, framing_err_cnt;
   logic       overflow_sticky;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rd_count = 0;
   int acc_cyc = 0;
   int base = 0;
   bit seen = 1'b0;
   logic [7:0] exp_wr[$];
   logic [7:0] exp_rx[$];
   logic [7:0] strobe_log[$];
   int         wr_cycs[$];

   uart_stream_bridge #(.RX_DEPTH(4), .TX_HOLDOFF(2), .RD_HOLDOFF(2), .DROP_ERR(1'b1)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_err(rx_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .UART_CSN(UART_CSN), .UART_WEN(UART_WEN), .UART_OEN(UART_OEN),
      .UART_DATA_IN(UART_DATA_IN), .UART_DATA_OUT(UART_DATA_OUT),
      .UART_TXRDY(UART_TXRDY), .UART_RXRDY(UART_RXRDY),
      .UART_PARITY_ERR(UART_PARITY_ERR), .UART_FRAMING_ERR(UART_FRAMING_ERR),
      .UART_OVERFLOW(UART_OVERFLOW), .clr_status(clr_status),
      .parity_err_cnt(parity_err_cnt), .framing_err_cnt(framing_err_cnt),
      .overflow_sticky(overflow_sticky)
   );

   initial forever #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion, expected finish before 1 ms");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name, input string what);
      tests++;
      fails++;
      $display("FAIL %s: %s", name, what);
   endtask

   task automatic monitor();
      forever begin
         @(negedge CLK);
         if (RESET_N) begin
            if (!UART_CSN) begin
               chk("strobe_one_hot", UART_WEN ^ UART_OEN, 1);
               if (!UART_WEN) begin
                  strobe_log.push_back(W_EV);
                  wr_cycs.push_back(cyc);
                  if (exp_wr.size() == 0) note_fail("uart_wr_data", "got unexpected write, expected none");
                  else chk("uart_wr_data", UART_DATA_IN, exp_wr.pop_front());
               end
               if (!UART_OEN) begin
                  strobe_log.push_back(R_EV);
                  rd_count++;
                  if (!(UART_PARITY_ERR || UART_FRAMING_ERR)) exp_rx.push_back(UART_DATA_OUT);
               end
            end else begin
               chk("strobe_idle", {UART_WEN, UART_OEN}, 2'b11);
            end
            if (rx_valid && rx_ready) begin
               if (exp_rx.size() == 0) note_fail("rx_pop", "got unexpected byte, expected none");
               else chk("rx_pop", {rx_err, rx_data}, {1'b0, exp_rx.pop_front()});
            end
         end
      end
   endtask

   task automatic send(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (tx_ready) begin
            ok = 1'b1;
            acc_cyc = cyc;
            break;
         end
      end
      if (!ok) note_fail("tx_accept", "got tx_ready=0 for 100 cycles, expected accept");
      else exp_wr.push_back(b);
      @(posedge CLK); #1;
   endtask

   task automatic wait_strobe(input bit want_wr, input string name);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (want_wr ? !UART_WEN : !UART_OEN) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) note_fail(name, "got no strobe in 100 cycles, expected one");
   endtask

   task automatic wait_log(input int n, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         if (strobe_log.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) note_fail(name, "got too few strobes in 300 cycles, expected more");
   endtask

   task automatic rx_read(input int extra, input bit clr_at_rd);
      UART_RXRDY = 1'b1;
      wait_strobe(1'b0, "rd_strobe");
      if (clr_at_rd) clr_status = 1'b1;
      repeat (extra) @(posedge CLK);
      @(posedge CLK); #1;
      UART_RXRDY = 1'b0;
      clr_status = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET_N = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; UART_DATA_OUT = '0;
      UART_TXRDY = 1'b1; UART_RXRDY = 1'b0; UART_PARITY_ERR = 1'b0; UART_FRAMING_ERR = 1'b0;
      UART_OVERFLOW = 1'b0; clr_status = 1'b0;
      fork monitor(); join_none

      repeat (2) @(negedge CLK);
      chk("rst_csn", UART_CSN, 1);
      chk("rst_wen", UART_WEN, 1);
      chk("rst_oen", UART_OEN, 1);
      chk("rst_data_in", UART_DATA_IN, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", {rx_err, rx_data}, 0);
      chk("rst_counters", {parity_err_cnt, framing_err_cnt, overflow_sticky}, 0);
      @(posedge CLK); #1 RESET_N = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      // single write: strobe two cycles after accept, one cycle wide
      send(8'hA5);
      tx_valid = 1'b0;
      wait_strobe(1'b1, "wr_a5");
      if (seen) begin
         chk("wr_latency", cyc - acc_cyc, 2);
         chk("wr_tx_ready_busy", tx_ready, 0);
         @(negedge CLK);
         chk("wr_tx_ready_free", tx_ready, 1);
         chk("wr_one_cycle", UART_WEN, 1);
      end

      // back-to-back writes with TXRDY held high
      repeat (6) @(posedge CLK);
      #1;
      wr_cycs.delete();
      send(8'h11);
      send(8'h22);
      send(8'h33);
      tx_valid = 1'b0;
      for (int i = 0; i < 100 && wr_cycs.size() < 3; i++) @(negedge CLK);
      if (wr_cycs.size() < 3) note_fail("wr_burst", "got fewer than 3 writes, expected 3");
      else begin
         chk("wr_spacing_1", wr_cycs[1] - wr_cycs[0], 4);
         chk("wr_spacing_2", wr_cycs[2] - wr_cycs[1], 4);
      end

      // single read, RXRDY lingers through the holdoff window
      @(posedge CLK); #1;
      UART_DATA_OUT = 8'h3C;
      base = rd_count;
      rx_read(2, 1'b0);
      repeat (6) @(negedge CLK);
      chk("rd_single_count", rd_count - base, 1);
      chk("rd_rx_valid", rx_valid, 1);
      chk("rd_rx_data", rx_data, 8'h3C);
      chk("rd_rx_err", rx_err, 0);
      @(posedge CLK); #1 rx_ready = 1'b1;
      @(posedge CLK); #1 rx_ready = 1'b0;
      @(negedge CLK);
      chk("rd_popped_empty", rx_valid, 0);

      // error reads are dropped but counted
      @(posedge CLK); #1;
      UART_PARITY_ERR = 1'b1;
      UART_DATA_OUT = 8'h55;
      rx_read(0, 1'b0);
      @(negedge CLK);
      chk("par_cnt_1", parity_err_cnt, 1);
      chk("par_frm_cnt_0", framing_err_cnt, 0);
      chk("par_dropped", rx_valid, 0);
      @(posedge CLK); #1;
      UART_PARITY_ERR = 1'b0;
      UART_FRAMING_ERR = 1'b1;
      rx_read(0, 1'b0);
      @(negedge CLK);
      chk("frm_cnt_1", framing_err_cnt, 1);
      chk("frm_par_cnt_1", parity_err_cnt, 1);
      chk("frm_dropped", rx_valid, 0);
      @(posedge CLK); #1;
      UART_FRAMING_ERR = 1'b0;
      UART_PARITY_ERR = 1'b1;
      base = rd_count;
      UART_RXRDY = 1'b1;
      for (int i = 0; i < 2000 && (rd_count - base) < 300; i++) @(negedge CLK);
      @(posedge CLK); #1 UART_RXRDY = 1'b0;
      repeat (6) @(negedge CLK);
      chk("par_300_reads", rd_count - base, 300);
      chk("par_saturated", parity_err_cnt, 8'hFF);
      chk("frm_unchanged", framing_err_cnt, 1);
      UART_PARITY_ERR = 1'b0;
      @(posedge CLK); #1 clr_status = 1'b1;
      @(posedge CLK); #1 clr_status = 1'b0;
      @(negedge CLK);
      chk("clr_counters", {parity_err_cnt, framing_err_cnt}, 0);
      @(posedge CLK); #1;
      UART_PARITY_ERR = 1'b1;
      rx_read(0, 1'b1);
      UART_PARITY_ERR = 1'b0;
      @(negedge CLK);
      chk("clr_with_event", parity_err_cnt, 1);
      chk("clr_with_event_frm", framing_err_cnt, 0);

      // sticky overflow
      @(posedge CLK); #1 UART_OVERFLOW = 1'b1;
      @(posedge CLK); #1 UART_OVERFLOW = 1'b0;
      repeat (3) @(negedge CLK);
      chk("sticky_set", overflow_sticky, 1);
      @(posedge CLK); #1 clr_status = 1'b1;
      @(posedge CLK); #1 clr_status = 1'b0;
      @(negedge CLK);
      chk("sticky_clr", overflow_sticky, 0);
      @(posedge CLK); #1 clr_status = 1'b1; UART_OVERFLOW = 1'b1;
      @(posedge CLK); #1 clr_status = 1'b0; UART_OVERFLOW = 1'b0;
      @(negedge CLK);
      chk("sticky_clr_and_set", overflow_sticky, 1);

      // FIFO fill: four reads, stall until a pop, then one more
      @(posedge CLK); #1;
      UART_DATA_OUT = 8'h80;
      base = rd_count;
      UART_RXRDY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_strobe(1'b0, "fill_rd");
         @(posedge CLK); #1 UART_DATA_OUT = UART_DATA_OUT + 8'd1;
      end
      repeat (12) @(negedge CLK);
      chk("full_reads", rd_count - base, 4);
      chk("full_csn_high", UART_CSN, 1);
      chk("full_head", {rx_err, rx_data}, 9'h080);
      @(posedge CLK); #1 rx_ready = 1'b1;
      @(posedge CLK); #1 rx_ready = 1'b0;
      wait_strobe(1'b0, "rd_after_pop");
      @(posedge CLK); #1 UART_RXRDY = 1'b0;
      repeat (6) @(negedge CLK);
      chk("full_reads_after_pop", rd_count - base, 5);
      @(posedge CLK); #1 rx_ready = 1'b1;
      repeat (8) @(negedge CLK);
      chk("full_drained", rx_valid, 0);
      chk("full_scoreboard_empty", exp_rx.size(), 0);

      // arbitration: last grant was a read, so a write goes first, then alternation
      @(posedge CLK); #1;
      UART_TXRDY = 1'b0;
      send(8'hC1);
      tx_valid = 1'b0;
      repeat (6) @(posedge CLK);
      #1;
      strobe_log.delete();
      UART_DATA_OUT = 8'h5A;
      UART_TXRDY = 1'b1;
      UART_RXRDY = 1'b1;
      fork
         begin
            send(8'hC2);
            send(8'hC3);
            tx_valid = 1'b0;
         end
         wait_log(6, "arb_alternate");
      join
      @(posedge CLK); #1 UART_RXRDY = 1'b0;
      if (strobe_log.size() >= 6)
         for (int i = 0; i < 6; i++) chk("arb_alternate", strobe_log[i], (i % 2 == 0) ? W_EV : R_EV);
      repeat (10) @(posedge CLK);
      #1;

      // last grant a write -> read goes first
      UART_TXRDY = 1'b0;
      send(8'hD1);
      tx_valid = 1'b0;
      @(posedge CLK); #1 UART_TXRDY = 1'b1;
      wait_strobe(1'b1, "wr_d1");
      @(posedge CLK); #1 UART_TXRDY = 1'b0;
      send(8'hD2);
      tx_valid = 1'b0;
      repeat (6) @(posedge CLK);
      #1;
      strobe_log.delete();
      UART_TXRDY = 1'b1;
      UART_RXRDY = 1'b1;
      wait_log(2, "arb_after_write");
      @(posedge CLK); #1 UART_RXRDY = 1'b0;
      if (strobe_log.size() >= 2) begin
         chk("arb_rr_first", strobe_log[0], R_EV);
         chk("arb_rr_second", strobe_log[1], W_EV);
      end
      repeat (10) @(posedge CLK);
      #1;

      // reset in the middle of a read strobe
      rx_ready = 1'b0;
      UART_DATA_OUT = 8'h99;
      UART_RXRDY = 1'b1;
      wait_strobe(1'b0, "rst_rd_first");
      wait_strobe(1'b0, "rst_rd_second");
      #1 RESET_N = 1'b0;
      #1;
      chk("rst_mid_oen", UART_OEN, 1);
      chk("rst_mid_csn", UART_CSN, 1);
      chk("rst_mid_fifo_empty", rx_valid, 0);
      chk("rst_mid_par_cnt", parity_err_cnt, 0);
      exp_rx.delete();
      exp_wr.delete();
      UART_RXRDY = 1'b0;
      @(posedge CLK); #1 RESET_N = 1'b1;

      // after reset, read wins the first contested grant
      UART_TXRDY = 1'b0;
      send(8'hE7);
      tx_valid = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      strobe_log.delete();
      UART_TXRDY = 1'b1;
      UART_RXRDY = 1'b1;
      wait_log(1, "arb_reset_first");
      @(posedge CLK); #1 UART_RXRDY = 1'b0;
      if (strobe_log.size() >= 1) chk("arb_reset_read_first", strobe_log[0], R_EV);
      rx_ready = 1'b1;
      repeat (10) @(negedge CLK);
      chk("end_wr_scoreboard_empty", exp_wr.size(), 0);
      chk("end_rx_scoreboard_empty", exp_rx.size(), 0);
      chk("end_rx_valid", rx_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
